// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among NREQ requesters.
// Each response carries the index of the requester that produced it.
module logic_unit_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [W*NREQ-1:0]    req_a,
    input  logic [W*NREQ-1:0]    req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic [15:0]          ops_done
);

    localparam int unsigned OPW = 3;
    localparam int unsigned CW  = 16;
    localparam logic [CW-1:0]  CNT_MAX    = '1;
    localparam logic [OPW-1:0] OP_ILLEGAL = 3'd7;

    logic [OPW-1:0] op_arr [NREQ];
    logic [W-1:0]   a_arr  [NREQ];
    logic [W-1:0]   b_arr  [NREQ];

    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q,  rsp_data_d;
    logic [IDW-1:0] rsp_id_q,    rsp_id_d;
    logic           rsp_err_q,   rsp_err_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [CW-1:0]  ops_done_q,  ops_done_d;

    logic           free;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] scan_idx;
    logic [OPW-1:0] gnt_op;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[OPW*g +: OPW];
        assign a_arr[g]  = req_a[W*g +: W];
        assign b_arr[g]  = req_b[W*g +: W];
    end

    function automatic logic [W-1:0] lu_eval(input logic [OPW-1:0] op,
                                             input logic [W-1:0]   a,
                                             input logic [W-1:0]   b);
        logic [W-1:0] y;
        case (op)
            3'd0:    y = ~a;
            3'd1:    y = a & b;
            3'd2:    y = a | b;
            3'd3:    y = ~(a & b);
            3'd4:    y = ~(a | b);
            3'd5:    y = a ^ b;
            3'd6:    y = ~(a ^ b);
            default: y = '0;
        endcase
        return y;
    endfunction

    // Scan from ptr with wrap; grant only when the response slot can take a result.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        free     = !rsp_valid_q || rsp_ready;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt_any = gnt_any && free && rst_n;
    end

    assign req_ready = gnt_any ? (NREQ'(1'b1) << gnt_idx) : '0;
    assign gnt_op    = op_arr[gnt_idx];

    // A grant reloads the response register; a retire without grant only drops valid.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        ptr_d       = ptr_q;
        ops_done_d  = ops_done_q;
        if (gnt_any) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = lu_eval(gnt_op, a_arr[gnt_idx], b_arr[gnt_idx]);
            rsp_id_d    = gnt_idx;
            rsp_err_d   = (gnt_op == OP_ILLEGAL);
            ptr_d       = IDW'((32'(gnt_idx) + 32'd1) % NREQ);
            if (ops_done_q != CNT_MAX) begin
                ops_done_d = ops_done_q + CW'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            ptr_q       <= '0;
            ops_done_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            ptr_q       <= ptr_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered W-bit bitwise logic unit (NOT/AND/OR/NAND/NOR/XOR/XNOR) among NREQ requesters.
- Round-robin arbitration, with a valid/ready handshake on every requester port and on the single response port.
- Response is tagged with the requester index.
- Sits between the per-lane control sequencers and the shared gate datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- IDW, 2, response tag width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronised externally.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; combinational, one-hot or zero.
- req_op  in  3*NREQ  opcode of requester i at bits [3i+2:3i].
- req_a  in  W*NREQ  operand a of requester i at bits [Wi+W-1:Wi].
- req_b  in  W*NREQ  operand b of requester i, same packing as req_a.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  W  result.
- rsp_id  out  IDW  index of the requester that produced this result.
- rsp_err  out  1  opcode was illegal.
- ops_done  out  16  count of accepted requests; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, ops_done=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - req_ready is 0 while in reset.
- Opcode decode:
  - 0 y=~a (b ignored); 1 a&b; 2 a|b; 3 ~(a&b); 4 ~(a|b); 5 a^b; 6 ~(a^b).
  - 7 is illegal: rsp_data=0, rsp_err=1, and the request is still consumed and counted.
- Slot free: free = !rsp_valid | rsp_ready.
- Grant (combinational):
  - If free, scan requesters starting at index ptr and wrapping modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - If not free, req_ready=0.
- Handshake on requester i: req_valid[i] & req_ready[i]. On that clock edge:
  - rsp_data <= f(op_i, a_i, b_i), rsp_id <= i, rsp_err <= (op_i==7), rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
  - ops_done increments unless it is already 16'hFFFF.
- Latency: exactly 1 cycle from request handshake to rsp_valid.
- Throughput: 1 operation per cycle while rsp_ready=1.
- Response retire: rsp_ready & rsp_valid with no new grant → rsp_valid <= 0 next edge.
  - rsp_data, rsp_id and rsp_err hold their last values.
- Simultaneous retire and grant: the register reloads with the new result and rsp_valid stays 1 (no bubble).
- Backpressure: while rsp_valid=1 & rsp_ready=0:
  - All rsp_* outputs are stable.
  - req_ready=0 and ptr is unchanged.
- Requester rule: once req_valid[i]=1, requester i holds op/a/b and valid until its handshake.
  - The arbiter does not check this; the bench asserts it on the stimulus side.
- No requests: ptr is unchanged and req_ready=0.
- Fairness: each continuously asserted requester is granted within NREQ grants.
- Reset mid-operation: any in-flight response is discarded immediately (rsp_valid=0) and ptr returns to 0.
- Width: operands and result are both W bits; no carries and no sign handling.

Test Plan:
- Reset, then requester 1 alone sends op=1, a=8'hF0, b=8'h3C → req_ready=4'b0010 that cycle; next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=1, rsp_err=0, ops_done=1.
- Requester 0 sweeps ops 0..6 with a=8'hA5, b=8'h0F, rsp_ready=1 → responses 5A, 05, AF, FA, 50, AA, 55 on consecutive cycles with no bubbles; op=7 → rsp_data=00, rsp_err=1, ops_done still increments.
- All four requesters hold valid, rsp_ready=1 → grants in order 0,1,2,3,0,1…; rsp_id follows the same sequence, one per cycle.
- All four valid, rsp_ready held low for 5 cycles after the first grant → rsp_data and rsp_id frozen, req_ready=0, ptr unchanged; on release the next grant goes to requester 1.
- rsp_valid=1 with rsp_ready=1 and requester 2 valid in the same cycle → rsp_valid stays 1 and the register updates to requester 2's result.
- Assert rst_n low mid-stream while rsp_valid=1 → rsp_valid=0 and ops_done=0 immediately, asynchronously, not waiting for an edge; after release requester 0 wins first.
- Force ops_done to 16'hFFFE and issue 3 requests → ops_done saturates at 16'hFFFF.
